i2c_slave_rx: RTL

- Receive-side counterpart to the I2C master clock/bit generator: a write-only I2C target.
- Oversamples the bus SCL/SDA on clk_in and detects START/STOP conditions.
- Shifts in the address byte, ACKs writes to its own 7-bit address, then receives data bytes and ACKs each one.
- Hands each received byte to the local datapath with a one-cycle valid strobe.

---
 rtl/i2c_slave_rx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
// Write-only I2C target. Oversamples SCL/SDA on clk_in, detects START/STOP,
// receives the address byte, ACKs writes to SLAVE_ADDR, then receives and
// ACKs data bytes until STOP or (repeated) START. Each received data byte is
// presented on rx_data with a one-cycle rx_valid strobe.
//
// Ports:
//   clk_in      system clock, at least 8x the SCL frequency
//   resetN      asynchronous active-low reset
//   scl_in      raw bus SCL (asynchronous)
//   sda_in      raw bus SDA (asynchronous)
//   sda_oe      1 = pull SDA low (open-drain enable)
//   rx_data     last received data byte
//   rx_valid    one-cycle strobe, rx_data is new
//   addr_match  high while in an addressed write transaction
//   start_det   one-cycle pulse on START / repeated START
//   stop_det    one-cycle pulse on STOP
//   busy        high whenever the FSM is not IDLE
//
// State table:
//   state    | meaning
//   IDLE     | bus free, waiting for START
//   ADDR     | shifting in the address byte
//   ADDR_ACK | driving ACK for our write address
//   DATA     | shifting in a data byte
//   DATA_ACK | driving ACK for a received data byte
//   IGNORE   | not addressed (or read request), wait for START/STOP
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       resetN,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    // Depths below 2 are not metastability-safe, so clamp.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    state_t            state;
    logic [STAGES-1:0] scl_sync;
    logic [STAGES-1:0] sda_sync;
    logic              scl_s, sda_s;
    logic              scl_p, sda_p;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;

    // Synchronizers and previous-sample flops idle high like the bus.
    always_ff @(posedge clk_in or negedge resetN) begin
        if (!resetN) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[STAGES-2:0], sda_in};
            scl_p    <= scl_s;
            sda_p    <= sda_s;
        end
    end

    assign scl_s = scl_sync[STAGES-1];
    assign sda_s = sda_sync[STAGES-1];

    logic scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    // SCL must be high in both samples, so an SCL edge coinciding with an
    // SDA edge is never taken as START or STOP.
    assign start_cond = scl_s & scl_p & ~sda_s &  sda_p;
    assign stop_cond  = scl_s & scl_p &  sda_s & ~sda_p;

    always_ff @(posedge clk_in or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;

            if (start_cond) begin
                state      <= ST_ADDR;
                bit_cnt    <= 4'd0;
                shift      <= 8'h00;
                addr_match <= 1'b0;
                sda_oe     <= 1'b0;
                start_det  <= 1'b1;
            end else if (stop_cond) begin
                state      <= ST_IDLE;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                stop_det   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift[7:1] == SLAVE_ADDR && !shift[0]) begin
                                sda_oe     <= 1'b1;
                                addr_match <= 1'b1;
                                state      <= ST_ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_IGNORE;
                            end
                        end
                    end

                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= ST_DATA;
                        end
                    end

                    ST_DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            sda_oe   <= 1'b1;
                            state    <= ST_DATA_ACK;
                        end
                    end

                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        sda_oe <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
